mem_port_arbiter: RTL and testbench

//   Shares one single-ported unified memory between the pipeline's fetch port (PCF/InstrF) and its data port (ALUResultM/WriteDataM/ReadDataM).

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports of the pipeline.
// Data has priority. A saturating starvation counter forces a fetch grant after MAX_WAIT data grants.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IReqF,
    input  logic [AW-1:0]   IAddrF,
    output logic [DW-1:0]   IRdataF,
    output logic            IValidF,
    output logic            StallMemF,
    input  logic            DReqM,
    input  logic            DWeM,
    input  logic [AW-1:0]   DAddrM,
    input  logic [DW-1:0]   DWdataM,
    input  logic [DW/8-1:0] DBeM,
    output logic [DW-1:0]   DRdataM,
    output logic            DValidM,
    output logic            StallMemM,
    output logic            MemReq,
    output logic            MemWe,
    output logic [AW-1:0]   MemAddr,
    output logic [DW-1:0]   MemWdata,
    output logic [DW/8-1:0] MemBe,
    input  logic            MemGnt,
    input  logic            MemRvalid,
    input  logic [DW-1:0]   MemRdata
);
    localparam logic [2:0] MaxWait = 3'(MAX_WAIT);

    typedef enum logic [2:0] {StIdle, StReqI, StWaitI, StReqD, StWaitD, StResp} state_e;

    state_e          stateQ, stateD;
    logic            respIsDataQ;
    logic [2:0]      starveCntQ;
    logic            cmdWeQ;
    logic [AW-1:0]   cmdAddrQ;
    logic [DW-1:0]   cmdWdataQ;
    logic [DW/8-1:0] cmdBeQ;
    logic [DW-1:0]   iRdataQ, dRdataQ;
    logic            dataWins, startD, startI;

    // Fetch only overtakes a pending data request once it has sat through MAX_WAIT data grants.
    assign dataWins = DReqM & ((starveCntQ < MaxWait) | ~IReqF);
    assign startD   = (stateQ == StIdle) & dataWins;
    assign startI   = (stateQ == StIdle) & ~dataWins & IReqF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (dataWins) begin
                    stateD = StReqD;
                end else if (IReqF) begin
                    stateD = StReqI;
                end
            end
            StReqI:  if (MemGnt) stateD = StWaitI;
            StWaitI: if (MemRvalid) stateD = StResp;
            StReqD:  if (MemGnt) stateD = StWaitD;
            StWaitD: if (MemRvalid) stateD = StResp;
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        MemReq  = 1'b0;
        IValidF = 1'b0;
        DValidM = 1'b0;
        unique case (stateQ)
            StReqI, StReqD: MemReq = 1'b1;
            StResp: begin
                IValidF = ~respIsDataQ;
                DValidM = respIsDataQ;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            respIsDataQ <= 1'b0;
            starveCntQ  <= '0;
            cmdWeQ      <= 1'b0;
            cmdAddrQ    <= '0;
            cmdWdataQ   <= '0;
            cmdBeQ      <= '0;
            iRdataQ     <= '0;
            dRdataQ     <= '0;
        end else begin
            if (startD) begin
                respIsDataQ <= 1'b1;
                cmdWeQ      <= DWeM;
                cmdAddrQ    <= DAddrM;
                cmdWdataQ   <= DWdataM;
                cmdBeQ      <= DWeM ? DBeM : '1;
            end else if (startI) begin
                respIsDataQ <= 1'b0;
                cmdWeQ      <= 1'b0;
                cmdAddrQ    <= IAddrF;
                cmdBeQ      <= '1;
            end
            if (stateQ == StIdle) begin
                if (!IReqF || startI) begin
                    starveCntQ <= '0;
                end else if (startD && (starveCntQ < MaxWait)) begin
                    starveCntQ <= starveCntQ + 3'd1;
                end
            end
            if ((stateQ == StWaitI) && MemRvalid) begin
                iRdataQ <= MemRdata;
            end
            // Store completions leave the load data register untouched.
            if ((stateQ == StWaitD) && MemRvalid && !cmdWeQ) begin
                dRdataQ <= MemRdata;
            end
        end
    end

    assign MemWe     = cmdWeQ;
    assign MemAddr   = cmdAddrQ;
    assign MemWdata  = cmdWdataQ;
    assign MemBe     = cmdBeQ;
    assign IRdataF   = iRdataQ;
    assign DRdataM   = dRdataQ;
    assign StallMemF = IReqF & ~IValidF;
    assign StallMemM = DReqM & ~DValidM;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters and memory, checked every cycle against
// a transaction-level model, plus directed reset-abort and starvation scenarios.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          IReqF = 1'b0;
    logic [AW-1:0] IAddrF = '0;
    logic [DW-1:0] IRdataF;
    logic          IValidF, StallMemF;
    logic          DReqM = 1'b0;
    logic          DWeM = 1'b0;
    logic [AW-1:0] DAddrM = '0;
    logic [DW-1:0] DWdataM = '0;
    logic [BW-1:0] DBeM = '0;
    logic [DW-1:0] DRdataM;
    logic          DValidM, StallMemM;
    logic          MemReq, MemWe;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWdata;
    logic [BW-1:0] MemBe;
    logic          MemGnt = 1'b0;
    logic          MemRvalid = 1'b0;
    logic [DW-1:0] MemRdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .IReqF(IReqF), .IAddrF(IAddrF), .IRdataF(IRdataF), .IValidF(IValidF), .StallMemF(StallMemF),
        .DReqM(DReqM), .DWeM(DWeM), .DAddrM(DAddrM), .DWdataM(DWdataM), .DBeM(DBeM),
        .DRdataM(DRdataM), .DValidM(DValidM), .StallMemM(StallMemM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemBe(MemBe),
        .MemGnt(MemGnt), .MemRvalid(MemRvalid), .MemRdata(MemRdata)
    );

    int unsigned nTests = 0;
    int unsigned nFails = 0;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nTests++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level view of the shared port: which transaction occupies it and in which phase.
    typedef enum int {PhFree, PhCmd, PhWait, PhResp} phase_e;
    phase_e        ph = PhFree;
    bit            mIsD = 1'b0;
    logic          mWe = 1'b0;
    logic [AW-1:0] mAddr = '0;
    logic [DW-1:0] mWdata = '0;
    logic [BW-1:0] mBe = '0;
    logic [DW-1:0] mIRd = '0;
    logic [DW-1:0] mDRd = '0;
    int            mCnt = 0;  // data grants the waiting fetch has sat through

    bit            randReq = 1'b1;
    int            gntPct = 60, rvPct = 50, spurPct = 10;
    bit            dirIReq = 1'b0, dirDReq = 1'b0;
    logic [AW-1:0] dirIAddr = '0, dirDAddr = '0;
    bit            logGrants = 1'b0;
    bit            grantLog[$];

    task automatic checkCycle();
        bit iPulse, dPulse;
        iPulse = (ph == PhResp) && !mIsD;
        dPulse = (ph == PhResp) && mIsD;
        checkVal("MemReq", MemReq, ph == PhCmd);
        if (ph == PhCmd) begin
            checkVal("cmd_we_addr_be", {MemWe, MemAddr, MemBe}, {mWe, mAddr, mBe});
            if (mIsD) checkVal("cmd_wdata", MemWdata, mWdata);
        end
        checkVal("IValidF", IValidF, iPulse);
        checkVal("DValidM", DValidM, dPulse);
        checkVal("IRdataF", IRdataF, mIRd);
        checkVal("DRdataM", DRdataM, mDRd);
        checkVal("StallMemF", StallMemF, IReqF & ~iPulse);
        checkVal("StallMemM", StallMemM, DReqM & ~dPulse);
    endtask

    task automatic planAndAdvance();
        bit dWin;
        if (randReq) begin
            if (IReqF) begin
                if (ph == PhResp && !mIsD) begin
                    IReqF = ($urandom_range(0, 3) != 0);
                    IAddrF = $urandom() & 32'hFFFF_FFFC;
                end else if ($urandom_range(0, 49) == 0) begin
                    IReqF = 1'b0;  // flush
                end
            end else if (!(ph != PhFree && !mIsD) && $urandom_range(0, 2) == 0) begin
                IReqF = 1'b1;
                IAddrF = $urandom() & 32'hFFFF_FFFC;
            end
            if (DReqM) begin
                if (ph == PhResp && mIsD) begin
                    DReqM = ($urandom_range(0, 3) != 0);
                end else if ($urandom_range(0, 49) == 0) begin
                    DReqM = 1'b0;
                end
            end else if (!(ph != PhFree && mIsD) && $urandom_range(0, 1) == 0) begin
                DReqM = 1'b1;
            end
            if (DReqM && !(DReqM && ph != PhFree && mIsD && ph != PhResp)) begin
                DWeM = $urandom_range(0, 1);
                DAddrM = $urandom();
                DWdataM = $urandom();
                DBeM = DWeM ? BW'($urandom_range(0, 15)) : '1;
            end
        end else begin
            IReqF = dirIReq;
            IAddrF = dirIAddr;
            DReqM = dirDReq;
            DWeM = 1'b0;
            DAddrM = dirDAddr;
            DWdataM = '0;
            DBeM = '1;
        end
        MemGnt = ($urandom_range(0, 99) < gntPct);
        MemRvalid = (ph == PhWait) ? ($urandom_range(0, 99) < rvPct)
                                   : ($urandom_range(0, 99) < spurPct);
        MemRdata = $urandom();

        case (ph)
            PhFree: begin
                dWin = DReqM && (mCnt < MAX_WAIT || !IReqF);
                if (!IReqF) mCnt = 0;
                else if (dWin) mCnt = (mCnt < MAX_WAIT) ? mCnt + 1 : mCnt;
                else mCnt = 0;
                if (dWin) begin
                    ph = PhCmd; mIsD = 1'b1; mWe = DWeM; mAddr = DAddrM;
                    mWdata = DWdataM; mBe = DBeM;
                end else if (IReqF) begin
                    ph = PhCmd; mIsD = 1'b0; mWe = 1'b0; mAddr = IAddrF; mBe = '1;
                end
            end
            PhCmd: if (MemGnt) ph = PhWait;
            PhWait: begin
                if (MemRvalid) begin
                    ph = PhResp;
                    if (!mIsD) mIRd = MemRdata;
                    else if (!mWe) mDRd = MemRdata;
                end
            end
            default: ph = PhFree;
        endcase
    endtask

    task automatic runCycle();
        @(negedge clk);
        if (logGrants && MemReq && MemGnt) grantLog.push_back(MemAddr == dirDAddr);
        checkCycle();
        planAndAdvance();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkVal("rst_MemReq", MemReq, 1'b0);
        checkVal("rst_valids", {IValidF, DValidM}, 2'b00);
        checkVal("rst_cmd", {MemWe, MemAddr, MemWdata, MemBe}, '0);
        checkVal("rst_rdata", {IRdataF, DRdataM}, '0);
        reset = 1'b1;
        planAndAdvance();

        repeat (4000) runCycle();

        // Drain, then abort a load in its wait phase with reset.
        randReq = 1'b0;
        gntPct = 100; rvPct = 100;
        repeat (8) runCycle();
        dirDReq = 1'b1; dirDAddr = 32'h2000;
        dirIAddr = 32'h100;
        rvPct = 0;
        repeat (3) runCycle();
        #2 reset = 1'b0;
        #1;
        checkVal("arst_MemReq", MemReq, 1'b0);
        checkVal("arst_valids", {IValidF, DValidM}, 2'b00);
        checkVal("arst_cmd", {MemWe, MemAddr, MemWdata, MemBe}, '0);
        checkVal("arst_rdata", {IRdataF, DRdataM}, '0);
        ph = PhFree; mCnt = 0; mIRd = '0; mDRd = '0;

        // Both ports held continuously: expect D,D,D,D,I repeating, starting with the reissued load.
        rvPct = 100;
        dirIReq = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        planAndAdvance();
        logGrants = 1'b1;
        repeat (48) runCycle();
        logGrants = 1'b0;
        checkVal("grant_count_ok", grantLog.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < grantLog.size(); i++) begin
            checkVal($sformatf("starve_pattern[%0d]", i), grantLog[i], (i % 5) != 4);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end
endmodule
